mci_wdt: RTL and testbench
==========================

// Module: mci_wdt
// PURPOSE
//  Two-stage cascaded watchdog timer. It consumes MCI_WDT_TIMEOUT_PERIOD_W from mci_pkg and sits
//  between the MCI CSR block (enables, periods, restarts, W1C) and the MCI interrupt and fatal-error
//  aggregation (timeout pulses, sticky NMI).
//  Timer1 expiry raises an error pulse; in cascade mode, timer2 then runs and its expiry asserts NMI.
//  Timer2 can also run independently when SW enables it explicitly.
// PARAMETERS
//  TIMEOUT_W  default mci_pkg::MCI_WDT_TIMEOUT_PERIOD_W (64)  width of counters and periods
// PORTS
//  clk             in   1          core clock
//  rst_b           in   1          asynchronous active-low reset
//  dbg_halt        in   1          1: both counters freeze (hold value), no timeouts
//  t1_en           in   1          timer1 enable
//  t1_restart      in   1          1-cycle pulse: timer1 count <= 0
//  t1_period       in   TIMEOUT_W  timer1 terminal count
//  t2_en           in   1          1: timer2 independent mode, 0: cascade mode
//  t2_restart      in   1          1-cycle pulse: timer2 count <= 0
//  t2_period       in   TIMEOUT_W  timer2 terminal count
//  t1_sts_clr      in   1          W1C pulse: clears t1_timeout_sts
//  t2_sts_clr      in   1          W1C pulse: clears t2_timeout_sts
//  t1_cnt          out  TIMEOUT_W  timer1 count (CSR readback)
//  t2_cnt          out  TIMEOUT_W  timer2 count (CSR readback)
//  t1_timeout_p    out  1          1-cycle pulse on timer1 expiry (error interrupt)
//  t2_timeout_p    out  1          1-cycle pulse on timer2 expiry
//  t1_timeout_sts  out  1          sticky timer1 expiry status
//  t2_timeout_sts  out  1          sticky timer2 expiry status
//  nmi_o           out  1          sticky fatal NMI request; cleared only by rst_b
// BEHAVIOUR
//  Reset: all outputs are 0, and both counters are 0.
//  Timer1 next-state, in per-cycle priority order:
//    1. !t1_en: count <= 0.
//    2. t1_restart: count <= 0, no pulse.
//    3. dbg_halt: hold.
//    4. count >= t1_period: count <= 0, t1_timeout_p <= 1, t1_timeout_sts <= 1.
//    5. Otherwise count <= count + 1.
//  Expiry timing: the compare is done before the increment, so count never wraps.
//    - t1_period = all-ones is legal.
//    - Pulse and status assert in the cycle after t1_cnt == t1_period.
//    - t1_period = 0: a pulse every enabled, non-halted cycle.
//  Timer2 run condition:
//    - Independent mode: t2_en.
//    - Cascade mode (!t2_en): t1_timeout_sts && t1_en.
//    - Run condition false: count <= 0.
//  Timer2 next state follows timer1 steps 2-5, using t2_restart, t2_period, t2_timeout_p and t2_timeout_sts.
//  Timer2 expiry also sets nmi_o <= 1. nmi_o holds until rst_b.
//  Cascade clear: when t1_sts_clr clears the status, timer2 returns to 0 on the next cycle.
//  Status set vs clear in the same cycle: set wins; the status stays 1.
//  t1_timeout_p and t2_timeout_p are registered pulses, never high for two consecutive cycles.
//    - Exception: period 0, where they repeat every cycle.
//  Period change while counting takes effect on the next compare.
//    - A new period <= the current count expires on the next cycle.
//  Mode switch t2_en 1->0 with t1_timeout_sts = 0: timer2 returns to 0 on the next cycle.
//  An rst_b assertion mid-count immediately zeroes counters, pulses, statuses and nmi_o.
// TESTING
//  1. t1_en=1, t1_period=5 -> t1_cnt 0..5; cycle 7 t1_timeout_p=1, t1_timeout_sts=1, t1_cnt=0.
//  2. Cascade mode (t2_en=0), t1_period=3, t2_period=4 -> t1 expires; t2 counts 0..4, then t2_timeout_p
//     and nmi_o=1. Then pulse t2_sts_clr -> nmi_o stays 1.
//  3. t1_period=10, t1_restart pulsed at count 9 -> t1_cnt=0, no pulse; expiry occurs 11 cycles later.
//  4. dbg_halt=1 for 20 cycles at t1_cnt=4 -> t1_cnt holds at 4 and no pulse; resumes at 5 after release.
//  5. In cascade, t1_sts_clr at t2_cnt=2 -> t2_cnt=0 next cycle; t1_timeout in the same cycle as clr -> sts stays 1.
//  6. t1_period=0 -> t1_timeout_p high every cycle.
//     Then rst_b low mid-count -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mci_wdt.sv
// Two-stage cascaded watchdog: timer1 expiry pulses an error; timer2 (cascaded or independent) raises sticky NMI.
// Latency: timeout pulse/status one cycle after cnt reaches period; no backpressure, every input sampled each cycle.
module mci_wdt #(
  parameter int unsigned TIMEOUT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 dbg_halt,
  input  logic                 t1_en,
  input  logic                 t1_restart,
  input  logic [TIMEOUT_W-1:0] t1_period,
  input  logic                 t2_en,
  input  logic                 t2_restart,
  input  logic [TIMEOUT_W-1:0] t2_period,
  input  logic                 t1_sts_clr,
  input  logic                 t2_sts_clr,
  output logic [TIMEOUT_W-1:0] t1_cnt,
  output logic [TIMEOUT_W-1:0] t2_cnt,
  output logic                 t1_timeout_p,
  output logic                 t2_timeout_p,
  output logic                 t1_timeout_sts,
  output logic                 t2_timeout_sts,
  output logic                 nmi_o
);

  logic [TIMEOUT_W-1:0] t1_cnt_q, t1_cnt_d;
  logic [TIMEOUT_W-1:0] t2_cnt_q, t2_cnt_d;
  logic                 t1_p_q, t1_p_d;
  logic                 t2_p_q, t2_p_d;
  logic                 t1_sts_q, t1_sts_d;
  logic                 t2_sts_q, t2_sts_d;
  logic                 nmi_q, nmi_d;
  logic                 t2_run;

  always_comb begin
    t1_cnt_d = t1_cnt_q;
    t1_p_d   = 1'b0;
    if (!t1_en || t1_restart) begin
      t1_cnt_d = '0;
    end else if (!dbg_halt) begin
      // Compare before increment so an all-ones period never wraps the counter.
      if (t1_cnt_q >= t1_period) begin
        t1_cnt_d = '0;
        t1_p_d   = 1'b1;
      end else begin
        t1_cnt_d = t1_cnt_q + TIMEOUT_W'(1);
      end
    end
    t1_sts_d = t1_p_d | (t1_sts_q & ~t1_sts_clr);
  end

  // Cascade drops out in the same cycle the W1C lands, so timer2 reads 0 on the next cycle.
  assign t2_run = t2_en | (t1_en & t1_sts_q & t1_sts_d);

  always_comb begin
    t2_cnt_d = t2_cnt_q;
    t2_p_d   = 1'b0;
    if (!t2_run || t2_restart) begin
      t2_cnt_d = '0;
    end else if (!dbg_halt) begin
      if (t2_cnt_q >= t2_period) begin
        t2_cnt_d = '0;
        t2_p_d   = 1'b1;
      end else begin
        t2_cnt_d = t2_cnt_q + TIMEOUT_W'(1);
      end
    end
    t2_sts_d = t2_p_d | (t2_sts_q & ~t2_sts_clr);
    nmi_d    = nmi_q | t2_p_d;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      t1_cnt_q <= '0;
      t2_cnt_q <= '0;
      t1_p_q   <= 1'b0;
      t2_p_q   <= 1'b0;
      t1_sts_q <= 1'b0;
      t2_sts_q <= 1'b0;
      nmi_q    <= 1'b0;
    end else begin
      t1_cnt_q <= t1_cnt_d;
      t2_cnt_q <= t2_cnt_d;
      t1_p_q   <= t1_p_d;
      t2_p_q   <= t2_p_d;
      t1_sts_q <= t1_sts_d;
      t2_sts_q <= t2_sts_d;
      nmi_q    <= nmi_d;
    end
  end

  assign t1_cnt         = t1_cnt_q;
  assign t2_cnt         = t2_cnt_q;
  assign t1_timeout_p   = t1_p_q;
  assign t2_timeout_p   = t2_p_q;
  assign t1_timeout_sts = t1_sts_q;
  assign t2_timeout_sts = t2_sts_q;
  assign nmi_o          = nmi_q;

endmodule

// File: tb/tb_mci_wdt.sv
// Bench for mci_wdt: directed scenarios plus random traffic, scored against a cycle-level reference model.
module tb_mci_wdt;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         dbg_halt, t1_en, t1_restart, t2_en, t2_restart, t1_sts_clr, t2_sts_clr;
  logic [W-1:0] t1_period, t2_period;
  logic [W-1:0] t1_cnt, t2_cnt;
  logic         t1_timeout_p, t2_timeout_p, t1_timeout_sts, t2_timeout_sts, nmi_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint unsigned c1;
    longint unsigned c2;
    bit p1, p2, s1, s2, nmi;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: plain integers, advanced once per clock from the observable rules.
  longint unsigned m1, m2;
  bit mp1, mp2, ms1, ms2, mn;

  mci_wdt #(.TIMEOUT_W(W)) dut (
    .clk(clk), .rst_b(rst_b), .dbg_halt(dbg_halt),
    .t1_en(t1_en), .t1_restart(t1_restart), .t1_period(t1_period),
    .t2_en(t2_en), .t2_restart(t2_restart), .t2_period(t2_period),
    .t1_sts_clr(t1_sts_clr), .t2_sts_clr(t2_sts_clr),
    .t1_cnt(t1_cnt), .t2_cnt(t2_cnt),
    .t1_timeout_p(t1_timeout_p), .t2_timeout_p(t2_timeout_p),
    .t1_timeout_sts(t1_timeout_sts), .t2_timeout_sts(t2_timeout_sts),
    .nmi_o(nmi_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m1 = 0; m2 = 0; mp1 = 0; mp2 = 0; ms1 = 0; ms2 = 0; mn = 0;
  endfunction

  // Advance the model by one clock using the inputs currently driven, and queue the result.
  function automatic void model_step();
    exp_t e;
    longint unsigned n1, n2;
    bit x1, x2, ns1, run2;
    x1 = 0; x2 = 0; n1 = m1; n2 = m2;
    if (!t1_en || t1_restart) n1 = 0;
    else if (!dbg_halt) begin
      if (m1 >= longint'(t1_period)) begin n1 = 0; x1 = 1; end
      else n1 = m1 + 1;
    end
    ns1 = x1 || (ms1 && !t1_sts_clr);
    run2 = t2_en || (t1_en && ms1 && !(t1_sts_clr && !x1));
    if (!run2 || t2_restart) n2 = 0;
    else if (!dbg_halt) begin
      if (m2 >= longint'(t2_period)) begin n2 = 0; x2 = 1; end
      else n2 = m2 + 1;
    end
    ms2 = x2 || (ms2 && !t2_sts_clr);
    mn  = mn || x2;
    m1 = n1; m2 = n2; mp1 = x1; mp2 = x2; ms1 = ns1;
    e.c1 = m1; e.c2 = m2; e.p1 = mp1; e.p2 = mp2; e.s1 = ms1; e.s2 = ms2; e.nmi = mn;
    exp_q.push_back(e);
  endfunction

  // Monitor: every clock after which an expectation was queued, compare all outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("t1_cnt", 64'(t1_cnt), e.c1);
        chk("t2_cnt", 64'(t2_cnt), e.c2);
        chk("t1_timeout_p", 64'(t1_timeout_p), 64'(e.p1));
        chk("t2_timeout_p", 64'(t2_timeout_p), 64'(e.p2));
        chk("t1_timeout_sts", 64'(t1_timeout_sts), 64'(e.s1));
        chk("t2_timeout_sts", 64'(t2_timeout_sts), 64'(e.s2));
        chk("nmi_o", 64'(nmi_o), 64'(e.nmi));
      end
    end
  end

  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " t1_cnt"}, 64'(t1_cnt), 0);
    chk({tag, " t2_cnt"}, 64'(t2_cnt), 0);
    chk({tag, " t1_timeout_p"}, 64'(t1_timeout_p), 0);
    chk({tag, " t2_timeout_p"}, 64'(t2_timeout_p), 0);
    chk({tag, " t1_timeout_sts"}, 64'(t1_timeout_sts), 0);
    chk({tag, " t2_timeout_sts"}, 64'(t2_timeout_sts), 0);
    chk({tag, " nmi_o"}, 64'(nmi_o), 0);
  endtask

  // Assert reset between clock edges; outputs must drop without waiting for a clock.
  task automatic async_reset(input string tag);
    #2 rst_b = 1'b0;
    #1 check_all_zero(tag);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, queue depth %0d expected 0", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_b = 1'b0; dbg_halt = 0; t1_en = 0; t1_restart = 0; t2_en = 0; t2_restart = 0;
    t1_sts_clr = 0; t2_sts_clr = 0; t1_period = '0; t2_period = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_b = 1'b1;
    run(2);

    // Timer1 to expiry, then cascade into timer2 and NMI; W1C on t2 status leaves NMI set.
    t1_period = 8'd5; t2_period = 8'd4; t1_en = 1;
    run(8);
    run(10);
    t2_sts_clr = 1; step(); t2_sts_clr = 0;
    run(3);

    // Restart just before expiry suppresses the pulse and re-arms a full period.
    t1_sts_clr = 1; t1_period = 8'd10; t1_restart = 1; step();
    t1_sts_clr = 0; t1_restart = 0;
    run(9);
    t1_restart = 1; step(); t1_restart = 0;
    run(14);

    // Debug halt freezes both counters.
    t1_sts_clr = 1; t1_restart = 1; step(); t1_sts_clr = 0; t1_restart = 0;
    run(4);
    dbg_halt = 1; run(20); dbg_halt = 0;
    run(3);

    // Cascade clear while timer2 is counting, then set-vs-clear collision.
    t1_period = 8'd3; t2_period = 8'd20;
    run(7);
    t1_sts_clr = 1; step(); t1_sts_clr = 0;
    run(3);
    t1_period = 8'd0;
    run(2);
    t1_sts_clr = 1; step(); t1_sts_clr = 0;
    run(4);

    // Independent timer2, mode switch back to cascade with timer1 status clear.
    t2_en = 1; t2_period = 8'd6; t1_en = 0;
    run(5);
    t2_en = 0; run(3);

    // All-ones period reaches its terminal count without wrapping.
    t1_en = 1; t1_period = 8'hFF; t1_sts_clr = 1; step(); t1_sts_clr = 0;
    run(262);

    // Period lowered below the current count expires on the next compare.
    t1_period = 8'd2; run(4);

    async_reset("mid-count reset");
    run(2);

    for (int i = 0; i < 3000; i++) begin
      t1_restart = ($urandom_range(0, 15) == 0);
      t2_restart = ($urandom_range(0, 19) == 0);
      t1_sts_clr = ($urandom_range(0, 9) == 0);
      t2_sts_clr = ($urandom_range(0, 9) == 0);
      dbg_halt   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) t1_en = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 39) == 0) t2_en = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 29) == 0) t1_period = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 29) == 0) t2_period = 8'($urandom_range(0, 12));
      step();
      if ($urandom_range(0, 499) == 0) async_reset("random reset");
    end

    t1_restart = 0; t2_restart = 0; t1_sts_clr = 0; t2_sts_clr = 0; dbg_halt = 0;
    t1_en = 1; t1_period = 8'd4; t2_en = 0; t2_period = 8'd2;
    run(20);
    async_reset("final reset");
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard drained", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
